// File: rtl/factorial_pkg.sv
// rtl/factorial_pkg.sv - shared state encoding for the factorial engine
package factorial_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/fact_ctrl.sv
// rtl/fact_ctrl.sv - IDLE/CALC/DONE controller issuing load, store and status strobes
module fact_ctrl
    import factorial_pkg::*;
(
    input  logic clk,
    input  logic resetn,
    input  logic in_valid,
    input  logic out_ready,
    input  logic i_lt_n,
    output logic ld_o,
    output logic st_o,
    output logic busy_o,
    output logic valid_o,
    output logic in_ready_o
);

    state_t state_q, state_d;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = CALC;
            CALC:    if (!i_lt_n)   state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready_o = (state_q == IDLE);
        ld_o       = (state_q == IDLE) && in_valid;
        busy_o     = (state_q == CALC);
        st_o       = (state_q == CALC) && !i_lt_n;
        valid_o    = (state_q == DONE);
    end

endmodule

// File: rtl/factorial_engine.sv
// rtl/factorial_engine.sv - iterative N! with one multiply per cycle and sticky overflow
module factorial_engine
    import factorial_pkg::*;
#(
    parameter int NW  = 8,
    parameter int W   = 16,
    parameter int SAT = 0
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NW-1:0] n_i,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [W-1:0]  result_o,
    output logic          ovf_o,
    output logic          busy_o
);

    logic [NW-1:0]   n_q, n_d, i_q, i_d, i_plus;
    logic [W-1:0]    acc_q, acc_d, result_q, result_d;
    logic            ovf_q, ovf_d, ovf_out_q, ovf_out_d;
    logic            lt_q, lt_d;
    logic [W+NW-1:0] prod;
    logic            ld, st, busy;

    fact_ctrl u_ctrl (
        .clk        (CLK),
        .resetn     (RST),
        .in_valid   (in_valid),
        .out_ready  (out_ready),
        .i_lt_n     (lt_q),
        .ld_o       (ld),
        .st_o       (st),
        .busy_o     (busy),
        .valid_o    (out_valid),
        .in_ready_o (in_ready)
    );

    assign i_plus = i_q + NW'(1);
    assign prod   = (W+NW)'(acc_q) * (W+NW)'(i_plus);

    // The loop-exit compare is registered one cycle behind the counter so the
    // controller never sees the multiplier path; capture forces one settle cycle.
    always_comb begin
        n_d       = n_q;
        i_d       = i_q;
        acc_d     = acc_q;
        ovf_d     = ovf_q;
        lt_d      = lt_q;
        result_d  = result_q;
        ovf_out_d = ovf_out_q;
        if (ld) begin
            n_d   = n_i;
            i_d   = NW'(1);
            acc_d = W'(1);
            ovf_d = 1'b0;
            lt_d  = 1'b1;
        end else if (busy) begin
            lt_d = (i_q < n_q);
            if (i_q < n_q) begin
                i_d   = i_plus;
                acc_d = prod[W-1:0];
                ovf_d = ovf_q | (|prod[W+NW-1:W]);
            end
        end
        if (st) begin
            result_d  = ((SAT != 0) && ovf_q) ? {W{1'b1}} : acc_q;
            ovf_out_d = ovf_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            n_q       <= '0;
            i_q       <= '0;
            acc_q     <= '0;
            ovf_q     <= 1'b0;
            lt_q      <= 1'b0;
            result_q  <= '0;
            ovf_out_q <= 1'b0;
        end else begin
            n_q       <= n_d;
            i_q       <= i_d;
            acc_q     <= acc_d;
            ovf_q     <= ovf_d;
            lt_q      <= lt_d;
            result_q  <= result_d;
            ovf_out_q <= ovf_out_d;
        end
    end

    assign result_o = result_q;
    assign ovf_o    = ovf_out_q;
    assign busy_o   = busy;

endmodule

// File: tb/tb_factorial_engine.sv
// tb/tb_factorial_engine.sv - directed self-checking bench for factorial_engine (SAT=0 and SAT=1)
module tb_factorial_engine;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        out_ready = 1'b0;
    logic [7:0]  n_i = 8'd0;
    logic        in_ready, out_valid, ovf_o, busy_o;
    logic [15:0] result_o;
    logic        s_in_ready, s_out_valid, s_ovf_o, s_busy_o;
    logic [15:0] s_result_o;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    factorial_engine #(.NW(8), .W(16), .SAT(0)) dut (
        .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(in_ready), .n_i(n_i),
        .out_valid(out_valid), .out_ready(out_ready), .result_o(result_o),
        .ovf_o(ovf_o), .busy_o(busy_o)
    );

    factorial_engine #(.NW(8), .W(16), .SAT(1)) dut_sat (
        .CLK(clk), .RST(rst), .in_valid(in_valid), .in_ready(s_in_ready), .n_i(n_i),
        .out_valid(s_out_valid), .out_ready(out_ready), .result_o(s_result_o),
        .ovf_o(s_ovf_o), .busy_o(s_busy_o)
    );

    task automatic accept(input logic [7:0] n);
        in_valid = 1'b1;
        n_i      = n;
        @(posedge clk); #1;
        in_valid = 1'b0;
        n_i      = 8'hAA;
    endtask

    task automatic wait_done(output int lat, output int busy_cnt);
        lat      = 0;
        busy_cnt = 0;
        do begin
            @(posedge clk); #1;
            lat++;
            if (busy_o) busy_cnt++;
        end while (!out_valid && lat < 400);
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        n_cmp++;
        if ({out_valid, busy_o, ovf_o, in_ready, result_o} !== {4'b0001, 16'd0}) begin
            n_bad++;
            $display("FAIL reset: ov/busy/ovf/ir/res=%b%b%b%b/%0d want 0001/0",
                     out_valid, busy_o, ovf_o, in_ready, result_o);
        end
    endtask

    task automatic test_basic();
        int lat, bc;
        accept(8'd5);
        wait_done(lat, bc);
        n_cmp++;
        if (lat !== 6) begin n_bad++; $display("FAIL n5_latency: got %0d want 6", lat); end
        n_cmp++;
        if (bc !== 5) begin n_bad++; $display("FAIL n5_busy: got %0d want 5", bc); end
        n_cmp++;
        if (result_o !== 16'd120 || ovf_o !== 1'b0) begin
            n_bad++; $display("FAIL n5_result: got %0d ovf %b want 120 ovf 0", result_o, ovf_o);
        end
        take_result();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            n_bad++; $display("FAIL n5_release: ov %b ir %b want 0 1", out_valid, in_ready);
        end
    endtask

    task automatic test_small();
        int lat, bc;
        logic [7:0] vals [2];
        vals[0] = 8'd0;
        vals[1] = 8'd1;
        foreach (vals[k]) begin
            accept(vals[k]);
            wait_done(lat, bc);
            n_cmp++;
            if (lat !== 2) begin n_bad++; $display("FAIL small_latency n=%0d: got %0d want 2", vals[k], lat); end
            n_cmp++;
            if (result_o !== 16'd1 || ovf_o !== 1'b0) begin
                n_bad++; $display("FAIL small_result n=%0d: got %0d ovf %b want 1 ovf 0", vals[k], result_o, ovf_o);
            end
            take_result();
        end
    endtask

    task automatic test_overflow();
        int lat, bc;
        accept(8'd8);
        wait_done(lat, bc);
        n_cmp++;
        if (result_o !== 16'h9D80 || ovf_o !== 1'b0) begin
            n_bad++; $display("FAIL n8: got %h ovf %b want 9d80 ovf 0", result_o, ovf_o);
        end
        n_cmp++;
        if (s_result_o !== 16'h9D80 || s_ovf_o !== 1'b0) begin
            n_bad++; $display("FAIL n8_sat: got %h ovf %b want 9d80 ovf 0", s_result_o, s_ovf_o);
        end
        take_result();
        accept(8'd9);
        wait_done(lat, bc);
        n_cmp++;
        if (result_o !== 16'h8980 || ovf_o !== 1'b1) begin
            n_bad++; $display("FAIL n9_wrap: got %h ovf %b want 8980 ovf 1", result_o, ovf_o);
        end
        n_cmp++;
        if (s_out_valid !== 1'b1 || s_result_o !== 16'hFFFF || s_ovf_o !== 1'b1) begin
            n_bad++; $display("FAIL n9_sat: ov %b got %h ovf %b want 1 ffff ovf 1", s_out_valid, s_result_o, s_ovf_o);
        end
        take_result();
    endtask

    task automatic test_backpressure();
        int lat, bc;
        int held_bad = 0;
        accept(8'd4);
        wait_done(lat, bc);
        for (int c = 0; c < 10; c++) begin
            in_valid = c[0];
            n_i      = 8'(c * 17);
            @(posedge clk); #1;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || result_o !== 16'd24 || busy_o !== 1'b0)
                held_bad++;
        end
        in_valid = 1'b0;
        n_cmp++;
        if (held_bad !== 0) begin
            n_bad++; $display("FAIL bp_hold: %0d bad cycles, last res %0d ov %b ir %b want 0 bad", held_bad, result_o, out_valid, in_ready);
        end
        take_result();
        n_cmp++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || result_o !== 16'd24) begin
            n_bad++; $display("FAIL bp_release: ov %b ir %b res %0d want 0 1 24", out_valid, in_ready, result_o);
        end
        accept(8'd3);
        wait_done(lat, bc);
        n_cmp++;
        if (result_o !== 16'd6 || lat !== 4) begin
            n_bad++; $display("FAIL bp_next: res %0d lat %0d want 6 lat 4", result_o, lat);
        end
        take_result();
    endtask

    task automatic test_reset_mid();
        int lat, bc;
        accept(8'd7);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        n_cmp++;
        if (out_valid !== 1'b0 || busy_o !== 1'b0 || in_ready !== 1'b1 || result_o !== 16'd0 || ovf_o !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset: ov %b busy %b ir %b res %0d ovf %b want 0 0 1 0 0",
                              out_valid, busy_o, in_ready, result_o, ovf_o);
        end
        accept(8'd3);
        wait_done(lat, bc);
        n_cmp++;
        if (result_o !== 16'd6 || ovf_o !== 1'b0) begin
            n_bad++; $display("FAIL mid_reset_next: res %0d ovf %b want 6 0", result_o, ovf_o);
        end
        take_result();
    endtask

    task automatic test_boundary();
        int lat, bc;
        accept(8'd255);
        wait_done(lat, bc);
        n_cmp++;
        if (lat !== 256 || out_valid !== 1'b1) begin
            n_bad++; $display("FAIL n255_latency: got %0d ov %b want 256 1", lat, out_valid);
        end
        n_cmp++;
        if (ovf_o !== 1'b1 || s_result_o !== 16'hFFFF) begin
            n_bad++; $display("FAIL n255_ovf: ovf %b sat_res %h want 1 ffff", ovf_o, s_result_o);
        end
        take_result();
        accept(8'd2);
        wait_done(lat, bc);
        n_cmp++;
        if (result_o !== 16'd2 || ovf_o !== 1'b0 || lat !== 3) begin
            n_bad++; $display("FAIL post_boundary: res %0d ovf %b lat %0d want 2 0 3", result_o, ovf_o, lat);
        end
        take_result();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_small();
        test_overflow();
        test_backpressure();
        test_reset_mid();
        test_boundary();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
